// File: rtl/mod_exp_engine.sv
// Modular exponentiation core: result = base^exponent mod modulus.
// Right-to-left square-and-multiply over a bit-serial interleaved modular multiplier.
module mod_exp_engine #(
    parameter int unsigned WIDTH = 256
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] exponent,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHKM,
        S_REDUCE,
        S_CHECK,
        S_MUL,
        S_SQR,
        S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   e_q, e_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   r_q, r_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               error_q, error_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [WIDTH-1:0]   mm_a;
    logic [WIDTH:0]     dbl_raw;
    logic [WIDTH-1:0]   dbl_red;
    logic [WIDTH:0]     sum_raw;
    logic [WIDTH-1:0]   mm_res;
    logic               mm_last;

    // One multiplier step: R = 2R mod M, then conditionally add A mod M; multiplier is always B.
    always_comb begin
        case (state_q)
            S_REDUCE: mm_a = WIDTH'(1);
            S_MUL:    mm_a = acc_q;
            default:  mm_a = b_q;
        endcase
        dbl_raw = {r_q, 1'b0};
        dbl_red = (dbl_raw >= {1'b0, m_q}) ? WIDTH'(dbl_raw - {1'b0, m_q}) : WIDTH'(dbl_raw);
        sum_raw = b_q[cnt_q] ? ({1'b0, dbl_red} + {1'b0, mm_a}) : {1'b0, dbl_red};
        mm_res  = (sum_raw >= {1'b0, m_q}) ? WIDTH'(sum_raw - {1'b0, m_q}) : WIDTH'(sum_raw);
        mm_last = (cnt_q == '0);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state_q;
        b_d      = b_q;
        e_d      = e_q;
        m_d      = m_q;
        acc_d    = acc_q;
        r_d      = r_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    b_d     = base;
                    e_d     = exponent;
                    m_d     = modulus;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                    state_d = S_CHKM;
                end
            end
            S_CHKM: begin
                if (m_q == '0) begin
                    error_d  = 1'b1;
                    acc_d    = '0;
                    result_d = '0;
                    done_d   = 1'b1;
                    state_d  = S_FINISH;
                end else begin
                    acc_d   = (m_q == WIDTH'(1)) ? '0 : WIDTH'(1);
                    r_d     = '0;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = S_REDUCE;
                end
            end
            S_REDUCE, S_MUL, S_SQR: begin
                r_d   = mm_res;
                cnt_d = cnt_q - CNT_W'(1);
                if (mm_last) begin
                    // Rearm the multiplier so the next MM can start without a setup cycle.
                    r_d   = '0;
                    cnt_d = CNT_W'(WIDTH - 1);
                    case (state_q)
                        S_REDUCE: begin
                            b_d     = mm_res;
                            state_d = S_CHECK;
                        end
                        S_MUL: begin
                            acc_d = mm_res;
                            e_d   = {e_q[WIDTH-1:1], 1'b0};
                            if (e_q[WIDTH-1:1] == '0) begin
                                result_d = mm_res;
                                done_d   = 1'b1;
                                state_d  = S_FINISH;
                            end else begin
                                state_d = S_SQR;
                            end
                        end
                        default: begin
                            b_d     = mm_res;
                            e_d     = e_q >> 1;
                            state_d = S_CHECK;
                        end
                    endcase
                end
            end
            S_CHECK: begin
                if (e_q == '0) begin
                    result_d = acc_q;
                    done_d   = 1'b1;
                    state_d  = S_FINISH;
                end else if (e_q[0]) begin
                    state_d = S_MUL;
                end else begin
                    state_d = S_SQR;
                end
            end
            S_FINISH: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            b_q      <= '0;
            e_q      <= '0;
            m_q      <= '0;
            acc_q    <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            e_q      <= e_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            result_q <= result_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;
    assign result = result_q;

endmodule

// File: tb/tb_mod_exp_engine.sv
// Bench for mod_exp_engine: a 16-bit and a 256-bit instance checked against
// a wide-integer square-and-multiply model and a per-bit latency model.
module tb_mod_exp_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n;
    logic         s16;
    logic [15:0]  b16, e16, m16, r16;
    logic         busy16, done16, err16;
    logic         s256;
    logic [255:0] b256, e256, m256, r256;
    logic         busy256, done256, err256;

    int n_checks = 0;
    int n_pass   = 0;

    mod_exp_engine #(.WIDTH(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(s16), .base(b16), .exponent(e16),
        .modulus(m16), .busy(busy16), .done(done16), .error(err16), .result(r16)
    );

    mod_exp_engine #(.WIDTH(256)) dut256 (
        .clk(clk), .reset_n(reset_n), .start(s256), .base(b256), .exponent(e256),
        .modulus(m256), .busy(busy256), .done(done256), .error(err256), .result(r256)
    );

    // Plain-arithmetic reference: b^e mod m (0 for m==0).
    function automatic logic [255:0] ref_modexp(input logic [255:0] b, input logic [255:0] e,
                                                input logic [255:0] m);
        logic [511:0] r, x, mm;
        if (m == '0) return '0;
        mm = 512'(m);
        r  = 512'(1) % mm;
        x  = 512'(b) % mm;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return 256'(r);
    endfunction

    // Cycle of the done pulse, counting the cycle after the accept edge as 1.
    function automatic int ref_cycles(input logic [255:0] e, input int w);
        int msb;
        int total;
        msb = -1;
        for (int i = 0; i < 256; i++) if (e[i]) msb = i;
        if (msb < 0) return w + 3;
        total = w + 2;
        for (int i = 0; i <= msb; i++)
            total += 1 + (e[i] ? w : 0) + ((i < msb) ? w : 0);
        return total;
    endfunction

    function automatic logic [255:0] mod_inverse(input logic [255:0] a, input logic [255:0] phi);
        logic [511:0] r0, r1, t0, t1, q, tmp, p;
        p  = 512'(phi);
        r0 = p;
        r1 = 512'(a);
        t0 = '0;
        t1 = 512'(1);
        while (r1 != '0) begin
            q   = r0 / r1;
            tmp = r0 - q * r1;
            r0  = r1;
            r1  = tmp;
            tmp = (t0 + p - ((q * t1) % p)) % p;
            t0  = t1;
            t1  = tmp;
        end
        return 256'(t0);
    endfunction

    task automatic run16(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                         output logic [15:0] res, output logic err, output int cyc,
                         output int dones, output int busy_low);
        @(negedge clk);
        b16 = b; e16 = e; m16 = m; s16 = 1'b1;
        @(posedge clk); #1;
        s16 = 1'b0;
        b16 = 16'($urandom); e16 = 16'($urandom); m16 = 16'($urandom);
        cyc = 1; dones = 0; busy_low = 0;
        if (!busy16) busy_low++;
        while (!done16 && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            if (!busy16) busy_low++;
        end
        res = r16; err = err16;
        if (done16) dones = 1;
        @(posedge clk); #1;
        if (done16) dones++;
    endtask

    task automatic run256(input logic [255:0] b, input logic [255:0] e, input logic [255:0] m,
                          output logic [255:0] res, output logic err, output int cyc,
                          output int dones);
        @(negedge clk);
        b256 = b; e256 = e; m256 = m; s256 = 1'b1;
        @(posedge clk); #1;
        s256 = 1'b0;
        b256 = '0; e256 = '0; m256 = '0;
        cyc = 1; dones = 0;
        while (!done256 && cyc < 80000) begin
            @(posedge clk); #1;
            cyc++;
        end
        res = r256; err = err256;
        if (done256) dones = 1;
        @(posedge clk); #1;
        if (done256) dones++;
    endtask

    task automatic test_reset();
        n_checks++; if ({busy16, done16, err16} !== 3'b000) $display("FAIL reset16_flags got=%b exp=000", {busy16, done16, err16}); else n_pass++;
        n_checks++; if (r16 !== 16'd0) $display("FAIL reset16_result got=%0d exp=0", r16); else n_pass++;
        n_checks++; if ({busy256, done256, err256} !== 3'b000) $display("FAIL reset256_flags got=%b exp=000", {busy256, done256, err256}); else n_pass++;
        n_checks++; if (r256 !== 256'd0) $display("FAIL reset256_result got=%0h exp=0", r256); else n_pass++;
    endtask

    task automatic test_basic();
        logic [15:0] res; logic err; int cyc, dones, bl;
        run16(16'd4, 16'd13, 16'd497, res, err, cyc, dones, bl);
        n_checks++; if (res !== 16'd445) $display("FAIL basic_result got=%0d exp=445", res); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL basic_error got=%b exp=0", err); else n_pass++;
        n_checks++; if (dones != 1) $display("FAIL basic_done_pulses got=%0d exp=1", dones); else n_pass++;
        n_checks++; if (bl != 0) $display("FAIL basic_busy_low_cycles got=%0d exp=0", bl); else n_pass++;
        n_checks++; if (cyc != ref_cycles(256'd13, 16)) $display("FAIL basic_latency got=%0d exp=%0d", cyc, ref_cycles(256'd13, 16)); else n_pass++;
    endtask

    task automatic test_rsa16();
        logic [15:0] c, p, f; logic err; int cyc, dones, bl;
        run16(16'd65, 16'd17, 16'd3233, c, err, cyc, dones, bl);
        n_checks++; if (c !== 16'd2790) $display("FAIL rsa16_encrypt got=%0d exp=2790", c); else n_pass++;
        run16(c, 16'd2753, 16'd3233, p, err, cyc, dones, bl);
        n_checks++; if (p !== 16'd65) $display("FAIL rsa16_decrypt got=%0d exp=65", p); else n_pass++;
        n_checks++; if (cyc != ref_cycles(256'd2753, 16)) $display("FAIL rsa16_latency got=%0d exp=%0d", cyc, ref_cycles(256'd2753, 16)); else n_pass++;
        run16(16'd7, 16'd60, 16'd61, f, err, cyc, dones, bl);
        n_checks++; if (f !== 16'd1) $display("FAIL fermat61 got=%0d exp=1", f); else n_pass++;
    endtask

    task automatic test_edges();
        logic [15:0] res; logic err; int cyc, dones, bl;
        run16(16'd1234, 16'd1, 16'd97, res, err, cyc, dones, bl);
        n_checks++; if (res !== 16'd70) $display("FAIL base_ge_mod got=%0d exp=70", res); else n_pass++;
        run16(16'd2, 16'd10, 16'd1000, res, err, cyc, dones, bl);
        n_checks++; if (res !== 16'd24) $display("FAIL pow2_10 got=%0d exp=24", res); else n_pass++;
        run16(16'($urandom), 16'd0, 16'd1000, res, err, cyc, dones, bl);
        n_checks++; if (res !== 16'd1) $display("FAIL exp_zero got=%0d exp=1", res); else n_pass++;
        n_checks++; if (cyc != 19) $display("FAIL exp_zero_latency got=%0d exp=19", cyc); else n_pass++;
        run16(16'd0, 16'd0, 16'd1000, res, err, cyc, dones, bl);
        n_checks++; if (res !== 16'd1) $display("FAIL zero_pow_zero got=%0d exp=1", res); else n_pass++;
        run16(16'd0, 16'd9, 16'd1000, res, err, cyc, dones, bl);
        n_checks++; if (res !== 16'd0) $display("FAIL zero_base got=%0d exp=0", res); else n_pass++;
        run16(16'd77, 16'd5, 16'd1, res, err, cyc, dones, bl);
        n_checks++; if ({err, res} !== 17'd0) $display("FAIL mod_one got=err%b/%0d exp=err0/0", err, res); else n_pass++;
    endtask

    task automatic test_mod_zero();
        logic [15:0] res; logic err; int cyc, dones, bl;
        run16(16'd5, 16'd3, 16'd0, res, err, cyc, dones, bl);
        n_checks++; if (cyc != 2) $display("FAIL mod0_latency got=%0d exp=2", cyc); else n_pass++;
        n_checks++; if (err !== 1'b1) $display("FAIL mod0_error got=%b exp=1", err); else n_pass++;
        n_checks++; if (res !== 16'd0) $display("FAIL mod0_result got=%0d exp=0", res); else n_pass++;
        run16(16'd3, 16'd4, 16'd50, res, err, cyc, dones, bl);
        n_checks++; if ({err, res} !== {1'b0, 16'd31}) $display("FAIL mod0_recover got=err%b/%0d exp=err0/31", err, res); else n_pass++;
    endtask

    task automatic test_random();
        logic [15:0] b, e, m, res, exp_res; logic err; int cyc, dones, bl, exp_cyc;
        for (int i = 0; i < 24; i++) begin
            b = 16'($urandom);
            e = 16'($urandom);
            m = 16'($urandom);
            if (i % 8 == 0) m = 16'd0;
            if (i % 8 == 1) m = 16'd1;
            if (i % 8 == 2) e = 16'($urandom_range(0, 3));
            exp_res = 16'(ref_modexp(256'(b), 256'(e), 256'(m)));
            exp_cyc = (m == 16'd0) ? 2 : ref_cycles(256'(e), 16);
            run16(b, e, m, res, err, cyc, dones, bl);
            n_checks++; if (res !== exp_res || err !== (m == 16'd0)) $display("FAIL rand%0d_result b=%0d e=%0d m=%0d got=%0d/err%b exp=%0d", i, b, e, m, res, err, exp_res); else n_pass++;
            n_checks++; if (cyc != exp_cyc || dones != 1 || bl != 0) $display("FAIL rand%0d_timing got=cyc%0d/d%0d/bl%0d exp=cyc%0d/d1/bl0", i, cyc, dones, bl, exp_cyc); else n_pass++;
        end
    endtask

    task automatic test_busy_ignore();
        int cyc;
        @(negedge clk);
        b16 = 16'd4; e16 = 16'd13; m16 = 16'd497; s16 = 1'b1;
        @(posedge clk); #1;
        s16 = 1'b0;
        cyc = 1;
        while (!done16 && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 5 || cyc == 40) begin
                s16 = 1'b1; b16 = 16'd9; e16 = 16'd3; m16 = 16'd11;
            end else begin
                s16 = 1'b0;
            end
        end
        n_checks++; if (r16 !== 16'd445) $display("FAIL busy_ignore_result got=%0d exp=445", r16); else n_pass++;
        n_checks++; if (cyc != ref_cycles(256'd13, 16)) $display("FAIL busy_ignore_latency got=%0d exp=%0d", cyc, ref_cycles(256'd13, 16)); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if ({busy16, done16} !== 2'b00) $display("FAIL busy_ignore_idle got=%b exp=00", {busy16, done16}); else n_pass++;
    endtask

    task automatic test_start_held();
        logic [6:1] seen;
        logic       busy3;
        seen = '0;
        busy3 = 1'b1;
        @(negedge clk);
        b16 = 16'd8; e16 = 16'd8; m16 = 16'd0; s16 = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= 6; c++) begin
            seen[c] = done16;
            if (c == 3) busy3 = busy16;
            if (c == 6) s16 = 1'b0;
            if (c < 6) begin
                @(posedge clk); #1;
            end
        end
        n_checks++; if (seen !== 6'b010010) $display("FAIL start_held_done_cycles got=%b exp=010010", seen); else n_pass++;
        n_checks++; if (busy3 !== 1'b0) $display("FAIL start_held_idle_gap got=%b exp=0", busy3); else n_pass++;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        logic [15:0] res; logic err; int cyc, dones, bl, seen_done;
        run16(16'd5, 16'd1, 16'd7, res, err, cyc, dones, bl);
        @(negedge clk);
        b16 = 16'd3; e16 = 16'd2; m16 = 16'd1000; s16 = 1'b1;
        @(posedge clk); #1;
        s16 = 1'b0;
        repeat (24) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        n_checks++; if ({busy16, done16, err16} !== 3'b000) $display("FAIL reset_mid_flags got=%b exp=000", {busy16, done16, err16}); else n_pass++;
        n_checks++; if (r16 !== 16'd0) $display("FAIL reset_mid_result got=%0d exp=0", r16); else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            if (done16 || busy16) seen_done++;
        end
        n_checks++; if (seen_done != 0) $display("FAIL reset_mid_no_done got=%0d exp=0", seen_done); else n_pass++;
        run16(16'd2, 16'd10, 16'd1000, res, err, cyc, dones, bl);
        n_checks++; if (res !== 16'd24 || cyc != ref_cycles(256'd10, 16)) $display("FAIL reset_mid_fresh got=%0d/cyc%0d exp=24/cyc%0d", res, cyc, ref_cycles(256'd10, 16)); else n_pass++;
    endtask

    task automatic test_rsa256();
        logic [255:0] p, q, n, phi, d, msg, c_ref, c, back;
        logic [511:0] prod;
        logic err; int cyc, dones;
        p    = 256'd8475698667747010771;
        q    = 256'd11297384090418420749;
        prod = 512'(p) * 512'(q);
        n    = 256'(prod);
        prod = 512'(p - 256'd1) * 512'(q - 256'd1);
        phi  = 256'(prod);
        d    = mod_inverse(256'd65537, phi);
        msg  = 256'h2b4d0e3f7795eb00000000;
        c_ref = ref_modexp(msg, 256'd65537, n);
        run256(msg, 256'd65537, n, c, err, cyc, dones);
        n_checks++; if (c !== c_ref) $display("FAIL rsa256_encrypt got=%0h exp=%0h", c, c_ref); else n_pass++;
        n_checks++; if (cyc != ref_cycles(256'd65537, 256) || dones != 1 || err !== 1'b0) $display("FAIL rsa256_enc_timing got=cyc%0d/d%0d/e%b exp=cyc%0d/d1/e0", cyc, dones, err, ref_cycles(256'd65537, 256)); else n_pass++;
        run256(c, d, n, back, err, cyc, dones);
        n_checks++; if (back !== msg) $display("FAIL rsa256_decrypt got=%0h exp=%0h", back, msg); else n_pass++;
        n_checks++; if (cyc != ref_cycles(d, 256) || dones != 1) $display("FAIL rsa256_dec_timing got=cyc%0d/d%0d exp=cyc%0d/d1", cyc, dones, ref_cycles(d, 256)); else n_pass++;
    endtask

    initial begin
        reset_n = 1'b0;
        s16 = 1'b0; b16 = '0; e16 = '0; m16 = '0;
        s256 = 1'b0; b256 = '0; e256 = '0; m256 = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        reset_n = 1'b1;
        test_basic();
        test_rsa16();
        test_edges();
        test_mod_zero();
        test_random();
        test_busy_ignore();
        test_start_held();
        test_reset_mid();
        test_rsa256();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
